// File: rtl/uart_pkg.sv
// ==========================================================================
// uart_pkg - shared state encodings, parity modes and sizing helper for UART
// Revision: 1.0
// ==========================================================================
`default_nettype none

package uart_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  // Number of bits needed to count 0..value-1.
  function automatic int clogb2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_bit_timer.sv
// ==========================================================================
// uart_bit_timer - counts oversample ticks up to a programmable terminal count
// Revision: 1.0
// ==========================================================================
`default_nettype none

module uart_bit_timer #(
  parameter int CW = 5
) (
  input  logic          clk,
  input  logic          i_rst,
  input  logic          i_tick,
  input  logic          i_clear,
  input  logic [CW-1:0] i_term_m1,
  output logic          o_bit_end
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // A tick landing on the clear edge is deliberately discarded.
  assign o_bit_end = i_tick && !i_clear && (cnt_q == i_term_m1);

  always_comb begin
    cnt_d = cnt_q;
    if (i_clear || o_bit_end) begin
      cnt_d = '0;
    end else if (i_tick) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx_cfg.sv
// ==========================================================================
// uart_tx_cfg - UART transmitter with runtime data length, parity and stop bits
// Revision: 1.0
// ==========================================================================
`default_nettype none

module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int NB_DATA  = 8,
  parameter int NB_OVS   = 16,
  parameter int NB_NBITS = 4
) (
  input  logic                clk,
  input  logic                i_rst,
  input  logic                i_tick,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [NB_DATA-1:0]  i_data,
  input  logic [NB_NBITS-1:0] i_nbits,
  input  logic [1:0]          i_parity,
  input  logic                i_stop2,
  output logic                o_data,
  output logic                o_busy,
  output logic                o_txdone
);

  localparam int CW = clogb2(NB_OVS * 2);
  localparam int BW = clogb2(NB_DATA);
  localparam logic [NB_NBITS-1:0] C_NBITS_MAX = NB_NBITS'(NB_DATA);
  localparam logic [NB_NBITS-1:0] C_NBITS_MIN = NB_NBITS'(5);

  logic [2:0]          state_q,  state_d;
  logic [NB_DATA-1:0]  shreg_q,  shreg_d;
  logic [NB_NBITS-1:0] nbits_q,  nbits_d;
  logic [1:0]          par_q,    par_d;
  logic [BW-1:0]       bcnt_q,   bcnt_d;
  logic                stop2_q,  stop2_d;
  logic                acc_q,    acc_d;
  logic                data_q,   data_d;
  logic                txdone_q, txdone_d;

  logic                w_accept;
  logic                w_bit_end;
  logic                w_last_bit;
  logic                w_has_par;
  logic                w_par_sum;
  logic [CW-1:0]       w_term_m1;
  logic [NB_NBITS-1:0] w_nbits_eff;

  assign w_accept    = (state_q == ST_IDLE) && i_valid;
  assign w_nbits_eff = (i_nbits < C_NBITS_MIN || i_nbits > C_NBITS_MAX) ? C_NBITS_MAX : i_nbits;
  assign w_has_par   = (par_q == PAR_EVEN) || (par_q == PAR_ODD);
  assign w_last_bit  = (NB_NBITS'(bcnt_q) == nbits_q - NB_NBITS'(1));
  assign w_par_sum   = acc_q ^ shreg_q[0];
  assign w_term_m1   = (state_q == ST_STOP && stop2_q) ? CW'(2 * NB_OVS - 1) : CW'(NB_OVS - 1);

  uart_bit_timer #(
    .CW (CW)
  ) u_bit_timer (
    .clk       (clk),
    .i_rst     (i_rst),
    .i_tick    (i_tick),
    .i_clear   (w_accept),
    .i_term_m1 (w_term_m1),
    .o_bit_end (w_bit_end)
  );

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    nbits_d  = nbits_q;
    par_d    = par_q;
    stop2_d  = stop2_q;
    bcnt_d   = bcnt_q;
    acc_d    = acc_q;
    data_d   = data_q;
    txdone_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        data_d = 1'b1;
        if (i_valid) begin
          shreg_d = i_data;
          nbits_d = w_nbits_eff;
          par_d   = i_parity;
          stop2_d = i_stop2;
          bcnt_d  = '0;
          acc_d   = 1'b0;
          data_d  = 1'b0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (w_bit_end) begin
          state_d = ST_DATA;
          data_d  = shreg_q[0];
        end
      end
      ST_DATA: begin
        if (w_bit_end) begin
          acc_d   = w_par_sum;
          shreg_d = shreg_q >> 1;
          if (!w_last_bit) begin
            bcnt_d = bcnt_q + BW'(1);
            data_d = shreg_q[1];
          end else if (w_has_par) begin
            state_d = ST_PARITY;
            data_d  = (par_q == PAR_ODD) ? ~w_par_sum : w_par_sum;
          end else begin
            state_d = ST_STOP;
            data_d  = 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (w_bit_end) begin
          state_d = ST_STOP;
          data_d  = 1'b1;
        end
      end
      ST_STOP: begin
        data_d = 1'b1;
        if (w_bit_end) begin
          state_d  = ST_IDLE;
          txdone_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        data_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      shreg_q  <= '0;
      nbits_q  <= '0;
      par_q    <= PAR_NONE;
      stop2_q  <= 1'b0;
      bcnt_q   <= '0;
      acc_q    <= 1'b0;
      data_q   <= 1'b1;
      txdone_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      nbits_q  <= nbits_d;
      par_q    <= par_d;
      stop2_q  <= stop2_d;
      bcnt_q   <= bcnt_d;
      acc_q    <= acc_d;
      data_q   <= data_d;
      txdone_q <= txdone_d;
    end
  end

  assign o_ready  = (state_q == ST_IDLE);
  assign o_busy   = (state_q != ST_IDLE);
  assign o_data   = data_q;
  assign o_txdone = txdone_q;

endmodule

`default_nettype wire

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
Parametrised successor UART transmitter with runtime frame configuration: data length 5..NB_DATA, parity none/even/odd, and one or two stop bits. Valid/ready byte handshake and busy/done status. Sits between the host-side TX buffer/FIFO and the serial pin. Bit timing comes from the shared baud tick generator, one i_tick per oversample period.

Parameters:
NB_DATA, 8, maximum data bits per frame (>=5); width of i_data.
NB_OVS, 16, i_tick pulses per serial bit (>=2).
NB_NBITS, 4, width of i_nbits; must hold NB_DATA.

Ports:
clk  in  1  system clock
i_rst  in  1  asynchronous reset, active-high
i_tick  in  1  oversample tick, single-cycle pulse
i_valid  in  1  byte offered for transmission
o_ready  out  1  block accepts a byte this cycle (high only in IDLE)
i_data  in  NB_DATA  payload, LSB sent first; bits above i_nbits ignored
i_nbits  in  NB_NBITS  data bits per frame
i_parity  in  2  00 none, 01 even, 10 odd, 11 none
i_stop2  in  1  1 = two stop bits
o_data  out  1  serial line, registered
o_busy  out  1  frame in progress (state != IDLE)
o_txdone  out  1  one-cycle pulse at frame end

Behaviour:
- All state/outputs on posedge clk; i_rst asynchronously forces IDLE, o_data=1, o_ready=1, o_busy=0, o_txdone=0, counters and shift register = 0.
- Accept: i_valid && o_ready at a clk edge. At that edge: latch i_data into shift reg, latch i_nbits/i_parity/i_stop2, clear tick and bit counters, state -> START, o_data -> 0, o_ready -> 0. No extra latency.
- States: IDLE -> START -> DATA -> (PARITY if mode 01/10) -> STOP -> IDLE. Binary encoding from package.
- Bit timing: every bit lasts exactly NB_OVS i_tick pulses. The edge that samples the NB_OVS-th tick of a bit: tick counter -> 0, next bit value appears on o_data, state advances. Non-tick cycles hold everything.
- A tick coinciding with the accept edge is not counted.
- DATA: o_data = shift_reg[0]; shift right at each bit end; leave after latched nbits bits.
- Parity accumulated as XOR of transmitted data bits only. Even: bit = XOR. Odd: bit = ~XOR.
- STOP: o_data=1 for NB_OVS ticks, or 2*NB_OVS ticks if latched i_stop2.
- Frame end edge: state -> IDLE, o_txdone=1 for exactly one cycle, o_ready=1 from next cycle. With i_valid held, the next start bit begins one clk after the done pulse.
- i_nbits <5 or >NB_DATA: treated as NB_DATA.
- i_valid while busy: ignored, not queued. Config input changes mid-frame have no effect.
- Reset mid-frame: line returns high immediately; frame is abandoned; no o_txdone.
- Illegal state: recover to IDLE with o_data=1.
- Counter widths: clogb2(NB_OVS*2) for ticks, clogb2(NB_DATA) for bits. No wrap is possible within legal parameters.

Decomposition:
- Shared package uart_pkg contains:
  - state encodings;
  - parity mode constants PAR_NONE/PAR_EVEN/PAR_ODD;
  - the clogb2 function.
- One natural sub-module: uart_bit_timer.
  - Counts i_tick up to a programmable terminal count (NB_OVS or 2*NB_OVS) and emits a bit_end pulse.
  - Clears on a start strobe.
  - Reused later by the RX successor.
- Parity and shift logic stay in-line.

Test Plan:
Common setup: NB_DATA=8, NB_OVS=16; i_tick every clk unless noted.
1. 8N1, i_data=0xA5 -> line reads 0, then 1,0,1,0,0,1,0,1, then 1, each 16 clks; o_txdone pulses 160 ticks after accept; o_ready low throughout.
2. 7E1, i_data=0x35 (7 bits, four ones) -> parity bit 0; repeat with odd parity -> parity bit 1; frame is 10 bits (160 ticks).
3. 8O2, i_data=0xFF, i_tick every 4th clk -> parity 1, stop high for 32 ticks, frame 192 ticks = 768 clks; o_txdone exactly one cycle.
4. Back-to-back with i_valid held high, bytes 0x01 then 0x80 -> second start bit falls exactly 1 clk after the first o_txdone; o_busy drops for 1 cycle only.
5. Assert i_rst during data bit 3 of 0x5A -> o_data=1 the same cycle (async), no o_txdone; after release o_ready=1 and a fresh 0x5A frame is correct.
6. Mid-frame: pulse i_valid with 0x00 and flip i_parity/i_stop2 -> current frame unchanged, nothing queued. Then i_nbits=3 with 0xC3 -> sent as 8 data bits.
